// File: rtl/fault_injection_ctrl_if.sv
// Campaign request, control and status bundle of the fault injection sequencer.
interface fault_injection_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CNT_WIDTH-1:0] cfg_count;
  logic [CNT_WIDTH-1:0] cfg_interval;
  logic                 abort;
  logic                 flit_valid;
  logic                 inject_en;
  logic                 busy;
  logic                 done;
  logic [CNT_WIDTH-1:0] injected_count;

  modport master (
    output cfg_valid, cfg_count, cfg_interval, abort, flit_valid,
    input  cfg_ready, inject_en, busy, done, injected_count
  );

  modport slave (
    input  cfg_valid, cfg_count, cfg_interval, abort, flit_valid,
    output cfg_ready, inject_en, busy, done, injected_count
  );
endinterface

// File: rtl/fault_injection_ctrl.sv
// Sequences N bit-flip injections separated by a number of untouched valid flits.
// FAULT_INJECTION_CTRL_CONTINUOUS_EN: count==0 runs until abort/reset.
module fault_injection_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  fault_injection_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_INJECT = 2'd1;
  localparam logic [1:0] S_SKIP   = 2'd2;

  localparam logic [CNT_WIDTH-1:0] ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] MAXV = '1;

  logic [1:0]           r_state;
  logic [CNT_WIDTH-1:0] r_remaining;
  logic [CNT_WIDTH-1:0] r_interval;
  logic [CNT_WIDTH-1:0] r_skip;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_done;
  logic                 w_event;
  logic                 w_last;

`ifdef FAULT_INJECTION_CTRL_CONTINUOUS_EN
  logic r_cont;
  assign w_last = (r_remaining == ONE) && !r_cont;
`else
  assign w_last = (r_remaining == ONE);
`endif

  assign w_event = (r_state == S_INJECT) && bus.flit_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= ZERO;
      r_interval  <= ZERO;
      r_skip      <= ZERO;
      r_count     <= ZERO;
      r_done      <= 1'b0;
`ifdef FAULT_INJECTION_CTRL_CONTINUOUS_EN
      r_cont      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      // An aborted cycle still corrupted its flit, so it is counted.
      if (w_event && (r_count != MAXV))
        r_count <= r_count + ONE;
      unique case (r_state)
        S_IDLE: begin
          if (bus.cfg_valid) begin
            r_remaining <= bus.cfg_count;
            r_interval  <= bus.cfg_interval;
            r_count     <= ZERO;
`ifdef FAULT_INJECTION_CTRL_CONTINUOUS_EN
            r_cont  <= (bus.cfg_count == ZERO);
            r_state <= S_INJECT;
`else
            if (bus.cfg_count != ZERO)
              r_state <= S_INJECT;
            else
              r_done <= 1'b1;
`endif
          end
        end
        S_INJECT: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
          end else if (bus.flit_valid) begin
            r_remaining <= r_remaining - ONE;
            if (w_last) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else if (r_interval != ZERO) begin
              r_skip  <= r_interval;
              r_state <= S_SKIP;
            end
          end
        end
        S_SKIP: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
          end else if (bus.flit_valid) begin
            r_skip <= r_skip - ONE;
            if (r_skip == ONE)
              r_state <= S_INJECT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cfg_ready      = (r_state == S_IDLE);
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.inject_en      = (r_state == S_INJECT);
  assign bus.done           = r_done;
  assign bus.injected_count = r_count;

endmodule

// File: tb/tb_fault_injection_ctrl.sv
// Directed scenarios plus random traffic against a flit-gap reference model.
module tb_fault_injection_ctrl;
  localparam int W    = 16;
  localparam int MAXC = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fault_injection_ctrl_if #(.CNT_WIDTH(W)) bus();

  fault_injection_ctrl #(.CNT_WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit started = 1'b0;

  task automatic check(string nm, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a campaign is "gap" valid flits away from its next injection.
  bit m_busy, m_done, m_cont;
  int m_left, m_gap, m_cnt, m_iv;

  always @(posedge clk) begin : model
    bit ev;
    ev = m_busy && (m_gap == 0) && bus.flit_valid;
    if (rst) begin
      m_busy = 0; m_done = 0; m_cont = 0;
      m_left = 0; m_gap = 0; m_cnt = 0; m_iv = 0;
    end else begin
      m_done = 0;
      if (ev && m_cnt < MAXC) m_cnt++;
      if (!m_busy) begin
        if (bus.cfg_valid) begin
          m_cnt  = 0;
          m_left = int'(bus.cfg_count);
          m_iv   = int'(bus.cfg_interval);
          m_gap  = 0;
          m_cont = 0;
          if (bus.cfg_count != 0) m_busy = 1;
          else begin
`ifdef FAULT_INJECTION_CTRL_CONTINUOUS_EN
            m_busy = 1;
            m_cont = 1;
`else
            m_done = 1;
`endif
          end
        end
      end else if (bus.abort) begin
        m_busy = 0;
      end else if (ev) begin
        m_left--;
        if (!m_cont && m_left == 0) begin
          m_busy = 0;
          m_done = 1;
        end else begin
          m_gap = m_iv;
        end
      end else if (bus.flit_valid && m_gap > 0) begin
        m_gap--;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cfg_ready", bus.cfg_ready, !m_busy);
      check("busy", bus.busy, m_busy);
      check("inject_en", bus.inject_en, m_busy && m_gap == 0);
      check("done", bus.done, m_done);
      check("injected_count", bus.injected_count, m_cnt);
    end
  end

  task automatic drive(bit r, bit cv, int cnt, int iv, bit fv, bit ab);
    rst              = r;
    bus.cfg_valid    = cv;
    bus.cfg_count    = W'(cnt);
    bus.cfg_interval = W'(iv);
    bus.flit_valid   = fv;
    bus.abort        = ab;
    @(negedge clk);
  endtask

  task automatic idle(bit fv);
    drive(0, 0, 0, 0, fv, 0);
  endtask

  initial begin
    int ie, dn, mask, evn;
    bit seen;
    bit [6:0] pat;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    started = 1'b1;
    check("rst_ready", bus.cfg_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_count", bus.injected_count, 0);

    // count=3, interval=0, constant valid flits
    drive(0, 1, 3, 0, 1, 0);
    ie = 0; dn = -1;
    for (int i = 0; i < 6; i++) begin
      if (bus.inject_en) ie++;
      if (bus.done) dn = i;
      idle(1);
    end
    check("t1_inj_cycles", ie, 3);
    check("t1_done_at", dn, 3);
    check("t1_count", bus.injected_count, 3);

    // count=2, interval=2, pattern 1,0,1,1,0,1,1
    drive(0, 1, 2, 2, 0, 0);
    pat = 7'b1101101;
    mask = 0; dn = -1;
    for (int i = 0; i < 7; i++) begin
      if (bus.inject_en && pat[i]) mask |= (1 << i);
      if (bus.done) dn = i;
      idle(pat[i]);
    end
    check("t2_event_mask", mask, 7'b0100001);
    check("t2_done_at", dn, 6);
    check("t2_count", bus.injected_count, 2);

    // count=5, interval=1, abort coinciding with third event
    drive(0, 1, 5, 1, 0, 0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.done) seen = 1;
      drive(0, 0, 0, 0, 1, i == 4);
    end
    check("t3_count", bus.injected_count, 3);
    check("t3_ready", bus.cfg_ready, 1);
    for (int i = 0; i < 3; i++) begin
      if (bus.done) seen = 1;
      idle(1);
    end
    check("t3_no_done", seen, 0);

    // reset during SKIP, then a single-shot campaign
    drive(0, 1, 4, 3, 0, 0);
    idle(1);
    check("t4_in_skip", bus.inject_en, 0);
    drive(1, 0, 0, 0, 1, 0);
    check("t4_rst_busy", bus.busy, 0);
    check("t4_rst_count", bus.injected_count, 0);
    drive(0, 1, 1, 0, 1, 0);
    evn = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.inject_en) evn++;
      idle(1);
    end
    check("t4_one_inj", evn, 1);
    check("t4_count", bus.injected_count, 1);

`ifdef FAULT_INJECTION_CTRL_CONTINUOUS_EN
    drive(0, 1, 0, 0, 1, 0);
    ie = 0;
    for (int i = 0; i < 70000; i++) begin
      if (!bus.inject_en) ie++;
      idle(1);
    end
    check("t5_low_cycles", ie, 0);
    check("t5_saturated", bus.injected_count, 65535);
    drive(0, 0, 0, 0, 1, 1);
    check("t5_abort_idle", bus.cfg_ready, 1);
`else
    drive(0, 1, 0, 0, 1, 0);
    check("t5_done", bus.done, 1);
    check("t5_no_inj", bus.inject_en, 0);
    idle(1);
    check("t5_done_clr", bus.done, 0);
    check("t5_count", bus.injected_count, 0);
`endif

    // cfg_valid held: second request accepted in the done cycle
    drive(0, 1, 2, 0, 1, 0);
    drive(0, 1, 2, 0, 1, 0);
    drive(0, 1, 2, 0, 1, 0);
    check("t6_done", bus.done, 1);
    check("t6_ready", bus.cfg_ready, 1);
    check("t6_prev_count", bus.injected_count, 2);
    drive(0, 1, 2, 0, 0, 0);
    check("t6_reaccepted", bus.busy, 1);
    check("t6_cleared", bus.injected_count, 0);
    drive(0, 0, 0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(299) == 0,
            $urandom_range(7) == 0,
            int'($urandom_range(5)),
            int'($urandom_range(3)),
            $urandom_range(1) == 1,
            $urandom_range(39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fault_injection_ctrl.md
# fault_injection_ctrl

Sequencer that drives the `enable` input of the link fault injection module directly downstream of it. It accepts a campaign of N bit-flip injections separated by a programmable number of untouched valid flits. It observes the same `flit_valid` the injector sees, so it counts exactly the flits that were corrupted. It sits next to the injector on each monitored link and is configured from the debug/control interface.

## Interface
Parameters:
- `CNT_WIDTH`, default 16: width of count, interval and statistics fields.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  reset; synchronous, active-high.
- `cfg_valid`  input  1  campaign request.
- `cfg_ready`  output  1  controller idle, request can be accepted.
- `cfg_count`  input  CNT_WIDTH  number of flits to corrupt.
- `cfg_interval`  input  CNT_WIDTH  valid flits left untouched between two injections.
- `abort`  input  1  terminate the running campaign.
- `flit_valid`  input  1  same signal fed to the injector's `flit_valid`.
- `inject_en`  output  1  to the injector's `enable`.
- `busy`  output  1  campaign running.
- `done`  output  1  one-cycle pulse when a campaign completes normally.
- `injected_count`  output  CNT_WIDTH  injections performed in the current or last campaign.

## Operation
- States: IDLE, INJECT, SKIP. All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- `cfg_ready` = (state == IDLE). `busy` = (state != IDLE). `inject_en` = (state == INJECT).
- Accept: `cfg_valid & cfg_ready`.
  - Latch `cfg_count` and `cfg_interval`.
  - Clear `injected_count`.
  - Clear the remaining-injection counter to `cfg_count`.
  - If `cfg_count != 0`, go to INJECT. Otherwise see Configuration.
- An injection event is `inject_en & flit_valid`.
  - Each event increments `injected_count`. The counter saturates at all-ones.
  - An event is counted even in a cycle where `abort` is high, because the flit was already corrupted.
- INJECT, on an event:
  - Decrement the remaining counter.
  - If remaining becomes 0: go to IDLE and pulse `done` next cycle.
  - Otherwise, if interval == 0: stay in INJECT, so consecutive valid flits are corrupted.
  - Otherwise: load the skip counter with the interval and go to SKIP.
- SKIP:
  - Decrement the skip counter on each `flit_valid`.
  - When `flit_valid` arrives with skip counter == 1, go to INJECT.
  - Cycles without `flit_valid` do not advance the counter.
- `abort` in INJECT or SKIP:
  - Go to IDLE next cycle.
  - No `done` pulse.
  - `injected_count` keeps its value.
- `abort` in IDLE has no effect. If `abort` and `cfg_valid` are both high in IDLE, the request is accepted.
- `cfg_valid` while busy is ignored, because `cfg_ready` is low.

## Timing
- Reset values, all outputs: state IDLE, `cfg_ready`=1, `busy`=0, `inject_en`=0, `done`=0, `injected_count`=0. Internal counters are also 0.
- Reset mid-campaign returns to IDLE on the next edge with all outputs at their reset values. `done` is not pulsed.
- Accept at edge k: `inject_en`=1 from cycle k+1.
- Last injection at cycle j: `inject_en`=0, `busy`=0, `cfg_ready`=1 and `done`=1 in cycle j+1. `done`=0 again in cycle j+2.
- A new request may be accepted in cycle j+1, the same cycle `done` is high.
- An injection event at cycle j with interval I ≥ 1:
  - `inject_en` is low from j+1.
  - `inject_en` is high again in the cycle after the I-th subsequent valid flit.
- The injector applies `enable & flit_valid` combinationally. The flit corrupted is therefore the one present in the cycle where `inject_en` and `flit_valid` are both high.

## Configuration
- Macro `FAULT_INJECTION_CTRL_CONTINUOUS_EN`.
- Defined:
  - `cfg_count == 0` starts a continuous campaign: INJECT/SKIP cycling with the remaining counter ignored.
  - The campaign ends only by `abort` or `rst`. `done` never pulses for it.
  - `injected_count` saturates.
- Not defined:
  - `cfg_count == 0` is accepted without entering INJECT. `inject_en` never rises.
  - State stays IDLE. `done` pulses in the cycle after acceptance and `injected_count` = 0.
- Campaigns with nonzero count behave identically in both builds.

## Test plan
- count=3, interval=0, `flit_valid` constant 1 from accept → `inject_en` high exactly 3 cycles; `injected_count`=3; `done` one cycle after the third event.
- count=2, interval=2, `flit_valid` pattern 1,0,1,1,0,1,1… → events on the 1st and 4th valid flits; no event in between; `done` after the 4th valid flit; `injected_count`=2.
- count=5, interval=1, assert `abort` in a cycle with an event after 2 injections → `injected_count`=3; IDLE next cycle; `done` never high; `cfg_ready`=1.
- Assert `rst` during SKIP with count=4, interval=3 → next cycle all outputs at reset values; then accept count=1, interval=0 → exactly one injection.
- count=0: without macro → `done` pulse in the cycle after accept with no `inject_en`. With macro, interval=0, 70000 valid flits → `inject_en` stays high; `injected_count` saturates at 65535; `abort` returns to IDLE.
- `cfg_valid` held high throughout a campaign of count=2 → second request accepted in the `done` cycle; `injected_count` cleared to 0 on that accept.
